// File: rtl/capture_buffer.sv
// capture_buffer: circular pre-trigger sample recorder with a
// ready/valid readout of the frozen window.
module capture_buffer #(
    parameter int SAMPLE_DATA_WIDTH = 8,
    parameter int DEPTH             = 256,
    parameter int PRE_TRIGGER       = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         axiiv,
    input  logic [SAMPLE_DATA_WIDTH-1:0] axiid,
    input  logic                         triggered,
    input  logic                         arm,
    output logic                         axiov,
    output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
    output logic                         axiol,
    input  logic                         axior,
    output logic                         armed,
    output logic                         busy,
    output logic                         done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = SAMPLE_DATA_WIDTH;
    localparam logic [CW-1:0] PRE  = CW'(PRE_TRIGGER);
    localparam logic [CW-1:0] POST = CW'(DEPTH - PRE_TRIGGER);
    localparam logic [AW-1:0] PRE_OFS = AW'(PRE_TRIGGER);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        READOUT
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] start_ptr;
    logic [AW-1:0] rd_left;
    logic [AW-1:0] launch_ptr;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] fill;
    logic [CW-1:0] post_cnt;
    logic          trig_d;

    logic          rq_v;
    logic          rq_l;
    logic [DW-1:0] ram_q;

    logic          out_v;
    logic          out_l;
    logic [DW-1:0] out_d;

    logic          trig_rise;
    logic          fire;
    logic          wr_en;
    logic          last_wr;
    logic          rd_en;
    logic          mv;
    logic          xfer;

    assign trig_rise = triggered & ~trig_d;
    assign xfer      = out_v & axior;
    assign mv        = ~out_v | xfer;
    assign rd_addr   = last_wr ? launch_ptr : rd_ptr;

    assign axiov = out_v;
    assign axiod = out_d;
    assign axiol = out_l;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, write strobe and readout launch/issue decisions
    always_comb begin
        state_nxt  = state;
        wr_en      = 1'b0;
        fire       = 1'b0;
        last_wr    = 1'b0;
        rd_en      = 1'b0;
        launch_ptr = start_ptr;
        unique case (state)
            IDLE: begin
                if (arm) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                wr_en      = axiiv;
                launch_ptr = wr_ptr - PRE_OFS;
                fire       = trig_rise && (fill == PRE);
                if (fire) begin
                    state_nxt = CAPTURE;
                    if (axiiv && (POST == CW'(1))) begin
                        last_wr   = 1'b1;
                        state_nxt = READOUT;
                    end
                end
            end
            CAPTURE: begin
                wr_en = axiiv;
                if (axiiv && (post_cnt == POST - CW'(1))) begin
                    last_wr   = 1'b1;
                    state_nxt = READOUT;
                end
            end
            READOUT: begin
                rd_en = (rd_left != '0) && (~rq_v | mv);
                if (xfer && out_l) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (last_wr) begin
            rd_en = 1'b1;
        end
    end

    // Sample RAM: one write port, registered read port with enable
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= axiid;
        end
        if (rd_en) begin
            ram_q <= mem[rd_addr];
        end
    end

    // Pointers, counters, edge detect, read pipeline and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig_d    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            start_ptr <= '0;
            rd_left   <= '0;
            fill      <= '0;
            post_cnt  <= '0;
            rq_v      <= 1'b0;
            rq_l      <= 1'b0;
            out_v     <= 1'b0;
            out_l     <= 1'b0;
            out_d     <= '0;
            armed     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            trig_d <= triggered;

            if (state == IDLE && arm) begin
                fill     <= '0;
                post_cnt <= '0;
            end

            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (state == ARMED && fill != PRE) begin
                    fill <= fill + CW'(1);
                end
                if (fire || state == CAPTURE) begin
                    post_cnt <= post_cnt + CW'(1);
                end
            end

            if (fire) begin
                start_ptr <= launch_ptr;
            end

            if (last_wr) begin
                rd_ptr  <= launch_ptr + AW'(1);
                rd_left <= AW'(DEPTH - 1);
                rq_v    <= 1'b1;
                rq_l    <= 1'b0;
            end else if (rd_en) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_left <= rd_left - AW'(1);
                rq_v    <= 1'b1;
                rq_l    <= (rd_left == AW'(1));
            end else if (mv) begin
                rq_v <= 1'b0;
            end

            if (mv) begin
                out_v <= rq_v;
                if (rq_v) begin
                    out_d <= ram_q;
                    out_l <= rq_l;
                end else begin
                    out_l <= 1'b0;
                end
            end

            armed <= (state_nxt == ARMED);
            busy  <= (state_nxt != IDLE);
            done  <= xfer & out_l;
        end
    end

endmodule

// File: tb/tb_capture_buffer.sv
// tb_capture_buffer: scoreboard bench for capture_buffer with
// DEPTH=16, PRE_TRIGGER=4.
`timescale 1ns/1ps
module tb_capture_buffer;

    localparam int W = 8;
    localparam int D = 16;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         axiiv = 1'b0;
    logic [W-1:0] axiid = '0;
    logic         triggered = 1'b0;
    logic         arm = 1'b0;
    logic         axior = 1'b1;
    logic         bp = 1'b0;
    logic         axiov;
    logic [W-1:0] axiod;
    logic         axiol;
    logic         armed;
    logic         busy;
    logic         done;

    int n_chk = 0;
    int n_pass = 0;
    int n_xfer = 0;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    exp_t exp_q[$];

    logic         mon_en = 1'b0;
    logic         exp_done = 1'b0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] prev_d = '0;
    logic         prev_l = 1'b0;

    capture_buffer #(
        .SAMPLE_DATA_WIDTH(W),
        .DEPTH(D),
        .PRE_TRIGGER(P)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .axiiv(axiiv),
        .axiid(axiid),
        .triggered(triggered),
        .arm(arm),
        .axiov(axiov),
        .axiod(axiod),
        .axiol(axiol),
        .axior(axior),
        .armed(armed),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // downstream ready: tied high or ~30% random
    always begin
        @(posedge clk);
        #1;
        axior = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // monitor: pops the scoreboard on every transfer
    always @(negedge clk) begin
        if (mon_en) begin
            if (done || exp_done) chk("done", done, exp_done);
            if (stall_prev) begin
                chk("stall_valid", axiov, 1);
                chk("stall_data", axiod, prev_d);
                chk("stall_last", axiol, prev_l);
            end
            exp_done = 1'b0;
            if (axiov && axior && rst_n) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_out: got %0d, expected none",
                             axiod);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", axiod, e.d);
                    chk("out_last", axiol, e.l);
                    exp_done = e.l;
                end
            end
            stall_prev = axiov && !axior && rst_n;
            prev_d = axiod;
            prev_l = axiol;
        end
    end

    task automatic feed(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            axiiv = 1'b1;
            axiid = W'(first + i);
            tick();
        end
        axiiv = 1'b0;
    endtask

    task automatic push_window(input int first);
        for (int i = 0; i < D; i++) begin
            exp_t e;
            e.d = W'(first + i);
            e.l = (i == D - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("armed_after_arm", armed, 1);
        chk("busy_after_arm", busy, 1);
    endtask

    // n_pre samples, then an edge with the next sample, then the rest
    task automatic capture(input int first, input int n_pre);
        feed(first, n_pre);
        push_window(first + n_pre - P);
        triggered = 1'b1;
        feed(first + n_pre, D - P);
        triggered = 1'b0;
    endtask

    task automatic drain(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0 && busy === 1'b0) break;
            tick();
        end
        chk({name, "_left"}, exp_q.size(), 0);
        chk({name, "_idle"}, busy, 0);
    endtask

    initial begin
        int base;
        logic seen;

        repeat (2) tick();
        chk("rst_axiov", axiov, 0);
        chk("rst_axiol", axiol, 0);
        chk("rst_armed", armed, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick();

        // basic window with latency checks
        do_arm();
        capture(0, 10);
        chk("lat_n1_axiov", axiov, 0);
        chk("lat_n1_busy", busy, 1);
        chk("lat_n1_armed", armed, 0);
        tick();
        chk("lat_n2_axiov", axiov, 1);
        chk("lat_n2_axiod", axiod, 6);
        repeat (D) tick();
        chk("thru_done", done, 1);
        chk("thru_busy", busy, 0);
        drain("basic", 50);

        // early trigger ignored while fill < PRE_TRIGGER
        do_arm();
        feed(0, 2);
        triggered = 1'b1;
        tick();
        triggered = 1'b0;
        tick();
        chk("early_armed", armed, 1);
        feed(2, 6);
        push_window(4);
        triggered = 1'b1;
        feed(8, D - P);
        triggered = 1'b0;
        drain("early", 50);

        // wrap-around of the circular RAM
        do_arm();
        capture(0, 40);
        drain("wrap", 50);

        // backpressure
        bp = 1'b1;
        base = n_xfer;
        do_arm();
        capture(0, 10);
        drain("bp", 600);
        chk("bp_count", n_xfer - base, D);
        bp = 1'b0;
        tick();

        // trigger held high across arm
        triggered = 1'b1;
        repeat (2) tick();
        do_arm();
        feed(100, 6);
        chk("held_armed", armed, 1);
        triggered = 1'b0;
        tick();
        feed(106, P);
        push_window(106);
        triggered = 1'b1;
        feed(110, D - P);
        triggered = 1'b0;
        drain("held", 50);

        // reset in the middle of a readout
        base = n_xfer;
        do_arm();
        capture(50, 10);
        for (int i = 0; i < 100 && n_xfer < base + 5; i++) tick();
        chk("pre_reset_xfers", n_xfer - base, 5);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_axiov", axiov, 0);
        chk("mid_rst_busy", busy, 0);
        rst_n = 1'b1;
        exp_q.delete();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | done | axiov;
        end
        chk("mid_rst_quiet", seen, 0);
        do_arm();
        capture(0, 10);
        drain("after_rst", 50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
